// File: rtl/hog_pkg.sv
// Shared HOG pipeline definitions: scheduler state encoding
// and the kernel/coordinate width helpers used by lin_buff users.
package hog_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Flattened kernel width in bits.
   function automatic int kw_f(input int bufw,
                               input int bw,
                               input int bh);
      return bw * bh * bufw;
   endfunction

   // Counter width for a range of n values (at least 1 bit).
   function automatic int cw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/win_pos_cnt.sv
// Window position tracker: raster (wx,wy) plus stride phase counters.
// Ports: clk, rst (async high), clr_i (frame restart), adv_i (one
// non-border kernel consumed); wx_o/wy_o current position, fwd_o
// position lies on the stride grid, end_o final position of frame,
// last_o position is the final strided window.
module win_pos_cnt
   import hog_pkg::*;
#(
   parameter int IMG_WIDTH    = 40,
   parameter int IMG_HEIGHT   = 32,
   parameter int BLOCK_WIDTH  = 4,
   parameter int BLOCK_HEIGHT = 8,
   parameter int STRIDE_X     = 2,
   parameter int STRIDE_Y     = 4,
   parameter int XW           = cw_f(IMG_WIDTH),
   parameter int YW           = cw_f(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [XW-1:0] wx_o,
   output logic [YW-1:0] wy_o,
   output logic          fwd_o,
   output logic          end_o,
   output logic          last_o
);

   localparam int PXW = cw_f(STRIDE_X);
   localparam int PYW = cw_f(STRIDE_Y);

   localparam logic [XW-1:0] WMAX =
      XW'(IMG_WIDTH - BLOCK_WIDTH);
   localparam logic [YW-1:0] HMAX =
      YW'(IMG_HEIGHT - BLOCK_HEIGHT);
   // Largest coordinates that still sit on the stride grid.
   localparam logic [XW-1:0] MSX =
      XW'(((IMG_WIDTH - BLOCK_WIDTH) / STRIDE_X) * STRIDE_X);
   localparam logic [YW-1:0] MSY =
      YW'(((IMG_HEIGHT - BLOCK_HEIGHT) / STRIDE_Y) * STRIDE_Y);
   localparam logic [PXW-1:0] PXMAX = PXW'(STRIDE_X - 1);
   localparam logic [PYW-1:0] PYMAX = PYW'(STRIDE_Y - 1);

   logic [XW-1:0]  wx_q, wx_d;
   logic [YW-1:0]  wy_q, wy_d;
   logic [PXW-1:0] px_q, px_d;
   logic [PYW-1:0] py_q, py_d;

   // Phase counters replace a modulo: they restart with each wrap,
   // so phase==0 exactly when the coordinate is a stride multiple.
   always_comb begin
      wx_d = wx_q;
      wy_d = wy_q;
      px_d = px_q;
      py_d = py_q;
      if (clr_i) begin
         wx_d = '0;
         wy_d = '0;
         px_d = '0;
         py_d = '0;
      end else if (adv_i) begin
         if (wx_q == WMAX) begin
            wx_d = '0;
            px_d = '0;
            if (wy_q == HMAX) begin
               wy_d = '0;
               py_d = '0;
            end else begin
               wy_d = wy_q + YW'(1);
               py_d = (py_q == PYMAX) ? '0 : py_q + PYW'(1);
            end
         end else begin
            wx_d = wx_q + XW'(1);
            px_d = (px_q == PXMAX) ? '0 : px_q + PXW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wx_q <= '0;
         wy_q <= '0;
         px_q <= '0;
         py_q <= '0;
      end else begin
         wx_q <= wx_d;
         wy_q <= wy_d;
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign wx_o   = wx_q;
   assign wy_o   = wy_q;
   assign fwd_o  = (px_q == '0) && (py_q == '0);
   assign end_o  = (wx_q == WMAX) && (wy_q == HMAX);
   assign last_o = (wx_q == MSX) && (wy_q == MSY);

endmodule

// File: rtl/win_sched.sv
// Window scheduler between lin_buff and the HOG cell datapath: drops
// border and off-stride kernels, tags survivors with (x,y), flags
// first/last of the frame and owns lin_buff's k_ready.
// Ports: clk, rst (async high), start, lb_k_valid/lb_k_border/
// lb_kernel/lb_k_ready (lin_buff side), out_valid/out_ready/
// out_kernel/out_x/out_y/out_first/out_last (downstream), busy,
// frame_done. WIN_SCHED_STATS_EN adds drop_cnt and border_cnt.
module win_sched
   import hog_pkg::*;
#(
   parameter int BUFFER_WIDTH = 8,
   parameter int BLOCK_WIDTH  = 4,
   parameter int BLOCK_HEIGHT = 8,
   parameter int IMG_WIDTH    = 40,
   parameter int IMG_HEIGHT   = 32,
   parameter int STRIDE_X     = 2,
   parameter int STRIDE_Y     = 4,
   parameter int KW = kw_f(BUFFER_WIDTH, BLOCK_WIDTH, BLOCK_HEIGHT),
   parameter int XW = cw_f(IMG_WIDTH),
   parameter int YW = cw_f(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          lb_k_valid,
   input  logic          lb_k_border,
   input  logic [KW-1:0] lb_kernel,
   output logic          lb_k_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [KW-1:0] out_kernel,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic          out_first,
   output logic          out_last,
   output logic          busy,
   output logic          frame_done
`ifdef WIN_SCHED_STATS_EN
   ,
   output logic [15:0]   drop_cnt,
   output logic [15:0]   border_cnt
`endif
);

   state_t        state_q;
   logic          out_valid_q;
   logic          out_first_q;
   logic          out_last_q;
   logic [KW-1:0] out_kernel_q;
   logic [XW-1:0] out_x_q;
   logic [YW-1:0] out_y_q;
   logic          first_pend_q;
   logic          busy_q;
   logic          frame_done_q;

   logic [XW-1:0] wx;
   logic [YW-1:0] wy;
   logic          pos_fwd;
   logic          pos_end;
   logic          pos_last;
   logic          arm;
   logic          acc;
   logic          adv;
   logic          fwd;

   // The output slot may be refilled in the same cycle it drains.
   assign lb_k_ready = (state_q == S_RUN) &&
                       (!out_valid_q || out_ready);
   assign arm = start &&
                ((state_q == S_IDLE) || (state_q == S_DONE));
   assign acc = lb_k_valid && lb_k_ready;
   assign adv = acc && !lb_k_border;
   assign fwd = adv && pos_fwd;

   win_pos_cnt #(
      .IMG_WIDTH   (IMG_WIDTH),
      .IMG_HEIGHT  (IMG_HEIGHT),
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BLOCK_HEIGHT(BLOCK_HEIGHT),
      .STRIDE_X    (STRIDE_X),
      .STRIDE_Y    (STRIDE_Y),
      .XW          (XW),
      .YW          (YW)
   ) u_pos (
      .clk   (clk),
      .rst   (rst),
      .clr_i (arm),
      .adv_i (adv),
      .wx_o  (wx),
      .wy_o  (wy),
      .fwd_o (pos_fwd),
      .end_o (pos_end),
      .last_o(pos_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         out_valid_q  <= 1'b0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_kernel_q <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         first_pend_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (fwd) begin
            out_valid_q  <= 1'b1;
            out_kernel_q <= lb_kernel;
            out_x_q      <= wx;
            out_y_q      <= wy;
            out_first_q  <= first_pend_q;
            out_last_q   <= pos_last;
            first_pend_q <= 1'b0;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_RUN;
                  busy_q       <= 1'b1;
                  first_pend_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (adv && pos_end) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               // Slot holds at most the last forwarded kernel here;
               // it may already have left if the end was off-stride.
               if (!out_valid_q || out_ready) begin
                  state_q      <= S_DONE;
                  frame_done_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  state_q      <= S_RUN;
                  first_pend_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_kernel = out_kernel_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign out_first  = out_first_q;
   assign out_last   = out_last_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

`ifdef WIN_SCHED_STATS_EN
   logic [15:0] drop_cnt_q;
   logic [15:0] border_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q   <= '0;
         border_cnt_q <= '0;
      end else if (arm) begin
         drop_cnt_q   <= '0;
         border_cnt_q <= '0;
      end else begin
         if (adv && !pos_fwd && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;
         if (acc && lb_k_border && (border_cnt_q != 16'hFFFF))
            border_cnt_q <= border_cnt_q + 16'd1;
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign border_cnt = border_cnt_q;
`else
   // Statistics counters are not built.
`endif

endmodule
